hwinfo_axi_reader: RTL and testbench
====================================

# hwinfo_axi_reader

AXI4-Lite initiator that sweeps the hardware-information register file: on request it reads `REGNUM` consecutive `REG_DATA_WIDTH`-bit registers, extracts the correct lane from each wide beat, and streams them out with their index. On a separate request it writes the software-reset command (low nibble `4'b1111`) to the command register. It sits between on-chip control logic (boot sequencer, safety monitor) and the HwInfo register slave on the interconnect.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 12, AXI address width.
- `C_M_AXI_DATA_WIDTH`, 128, AXI data width; multiple of `REG_DATA_WIDTH`.
- `REG_DATA_WIDTH`, 64, width of one register.
- `REGNUM`, 16, registers per sweep (≥1).
- `BASE_ADDR`, 0, byte address of register 0.
- `CMD_ADR`, 31, register index of the command register.

Ports:
- `M_AXI_ACLK_i`  in  1  clock; the only clock.
- `M_AXI_ARESETN_i`  in  1  reset; asynchronous assert, active-low.
- `start_i`  in  1  pulse: begin read sweep (sampled in IDLE only).
- `rst_cmd_i`  in  1  pulse: request command write (latched as pending in any state).
- `busy_o`  out  1  high whenever not IDLE.
- `done_o`  out  1  one-cycle pulse when a sweep or command write completes.
- `err_o`  out  1  sticky: some RRESP/BRESP ≠ OKAY; cleared on accepted `start_i`/`rst_cmd_i`.
- `reg_valid_o`  out  1  one-cycle pulse; `reg_idx_o`/`reg_data_o` valid.
- `reg_idx_o`  out  $clog2(REGNUM)+1  register index.
- `reg_data_o`  out  REG_DATA_WIDTH  extracted lane.
- AXI4-Lite master: `M_AXI_AWADDR_o`, `M_AXI_AWVALID_o`, `M_AXI_AWREADY_i`, `M_AXI_WDATA_o`, `M_AXI_WSTRB_o`, `M_AXI_WVALID_o`, `M_AXI_WREADY_i`, `M_AXI_BRESP_i`[1:0], `M_AXI_BVALID_i`, `M_AXI_BREADY_o`, `M_AXI_ARADDR_o`, `M_AXI_ARVALID_o`, `M_AXI_ARREADY_i`, `M_AXI_RDATA_i`, `M_AXI_RRESP_i`[1:0], `M_AXI_RVALID_i`, `M_AXI_RREADY_o`; widths per parameters.

## Operation
- States: IDLE, AR, R, AW_W, B.
- IDLE: `start_i` → idx=0, AR. Else if command pending → AW_W. `start_i` wins when both are present; the command stays pending and runs after the sweep.
- AR: `ARVALID`=1, `ARADDR`=BASE_ADDR+idx·(REG_DATA_WIDTH/8). Hold address and valid stable until `ARREADY`, then → R.
- R: `RREADY`=1. On `RVALID`: select lane `ARADDR[$clog2(DATA_BYTES)-1:$clog2(REG_BYTES)]` of `RDATA`, register it, and pulse `reg_valid_o`. Non-OKAY `RRESP` sets `err_o` and the sweep continues. If idx=REGNUM-1 → pulse `done_o`, then IDLE (or AW_W if command pending). Else idx+1 → AR.
- AW_W: `AWVALID`=`WVALID`=1 together. `AWADDR`=BASE_ADDR+CMD_ADR·REG_BYTES. `WDATA` = the 64-bit value `0x...000F` replicated across all lanes. `WSTRB` = ones only on the addressed lane.
  - Each valid drops independently on its own ready.
  - Both handshaken (same or different cycles) → B; clear pending.
- B: `BREADY`=1. On `BVALID` → pulse `done_o`, and set `err_o` if `BRESP`≠0, then → IDLE.
- One outstanding transaction max; no AXI signal is ever withdrawn before its handshake.
- `rst_cmd_i` while a command is already pending: merged, one write only.

## Timing
- Reset (async): state IDLE; all VALID/READY outputs 0; `busy_o`, `done_o`, `err_o`, `reg_valid_o`, pending = 0; `reg_idx_o`, `reg_data_o`, addresses, `WDATA`, `WSTRB` = 0.
- Reset mid-transaction: outputs go to reset values immediately; no completion pulse.
- AXI outputs are registered.
  - `ARVALID` rises the cycle after `start_i`.
  - `reg_valid_o` rises the cycle after the R handshake.
  - The next `ARVALID` rises that same cycle.
- Zero-wait slave with 1-cycle ready: 4 cycles per register.

## Test plan
- Zero-wait slave, REGNUM=16, register k = 0x1000+k: `start_i` → 16 `reg_valid_o` pulses, idx 0..15, data 0x1000..0x100F, ARADDR 0x00,0x08,…,0x78. `done_o` fires once.
- Odd-index lane select at 128-bit bus: slave returns `{0xAAAA, 0xBBBB}` for ARADDR 0x08 → `reg_data_o`=0xAAAA. For 0x00 → 0xBBBB.
- `rst_cmd_i` alone: AWADDR=0xF8, WDATA low nibble 0xF in both lanes, WSTRB=0xFF00. With AWREADY 2 cycles before WREADY, each valid drops on its own ready. `done_o` follows BVALID.
- `start_i`+`rst_cmd_i` in the same cycle → full sweep, then one command write. A second `rst_cmd_i` mid-sweep yields no extra write.
- RRESP=2 on register 3 → `err_o`=1 and stays high; the sweep still completes 16 registers. The next `start_i` clears it.
- Random ARREADY/RVALID stalls (0–5 cycles) with `ARESETN` asserted mid-R → all outputs 0 asynchronously. A fresh sweep after reset is correct.

Source files
------------

// File: rtl/hwinfo_axi_reader.sv
// AXI4-Lite initiator for the HwInfo register file: sweeps REGNUM registers
// and streams each extracted lane out with its index, and issues the
// software-reset command write to the command register on request.
module hwinfo_axi_reader #(
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int REG_DATA_WIDTH     = 64,
    parameter int REGNUM             = 16,
    parameter int BASE_ADDR          = 0,
    parameter int CMD_ADR            = 31
) (
    input  logic                              M_AXI_ACLK_i,
    input  logic                              M_AXI_ARESETN_i,
    input  logic                              start_i,
    input  logic                              rst_cmd_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic                              reg_valid_o,
    output logic [$clog2(REGNUM):0]           reg_idx_o,
    output logic [REG_DATA_WIDTH-1:0]         reg_data_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR_o,
    output logic                              M_AXI_AWVALID_o,
    input  logic                              M_AXI_AWREADY_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA_o,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB_o,
    output logic                              M_AXI_WVALID_o,
    input  logic                              M_AXI_WREADY_i,
    input  logic [1:0]                        M_AXI_BRESP_i,
    input  logic                              M_AXI_BVALID_i,
    output logic                              M_AXI_BREADY_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR_o,
    output logic                              M_AXI_ARVALID_o,
    input  logic                              M_AXI_ARREADY_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA_i,
    input  logic [1:0]                        M_AXI_RRESP_i,
    input  logic                              M_AXI_RVALID_i,
    output logic                              M_AXI_RREADY_o
);

    localparam int AW        = C_M_AXI_ADDR_WIDTH;
    localparam int DW        = C_M_AXI_DATA_WIDTH;
    localparam int RW        = REG_DATA_WIDTH;
    localparam int REG_BYTES = RW / 8;
    localparam int LANES     = DW / RW;
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int REG_SHIFT = $clog2(REG_BYTES);
    localparam int IDX_W     = $clog2(REGNUM) + 1;
    localparam int CMD_BYTE  = BASE_ADDR + CMD_ADR * REG_BYTES;
    localparam int CMD_LANE  = (CMD_BYTE / REG_BYTES) % LANES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REGNUM - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              rvld_q, rvld_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [RW-1:0]     rdata_q, rdata_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;

    logic [DW-1:0]     cmd_wdata;
    logic [DW/8-1:0]   cmd_wstrb;
    logic [LANE_W-1:0] lane;
    logic [RW-1:0]     rd_lane;

    function automatic logic [AW-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return AW'(BASE_ADDR) + AW'(i) * AW'(REG_BYTES);
    endfunction

    // Command beat: 0xF in every lane, byte strobes only on the command register's lane.
    always_comb begin
        cmd_wdata = '0;
        cmd_wstrb = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            cmd_wdata[l*RW +: 4] = 4'hF;
            if (int'(l) == CMD_LANE) cmd_wstrb[l*REG_BYTES +: REG_BYTES] = '1;
        end
    end

    // Pick the register's lane out of the wide read beat using the held read address.
    always_comb begin
        lane    = (LANES > 1) ? LANE_W'(araddr_q >> REG_SHIFT) : '0;
        rd_lane = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (LANE_W'(l) == lane) rd_lane = M_AXI_RDATA_i[l*RW +: RW];
        end
    end

    // Next-state and registered-output logic for the sweep / command FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q | rst_cmd_i;
        err_d     = err_q;
        done_d    = 1'b0;
        rvld_d    = 1'b0;
        ridx_d    = ridx_q;
        rdata_d   = rdata_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_AR;
                    idx_d     = '0;
                    araddr_d  = reg_addr('0);
                    arvalid_d = 1'b1;
                    err_d     = 1'b0;
                end else if (pend_q) begin
                    state_d   = S_AW_W;
                    awaddr_d  = AW'(CMD_BYTE);
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    err_d     = 1'b0;
                end
            end
            S_AR: begin
                if (M_AXI_ARREADY_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (M_AXI_RVALID_i) begin
                    rready_d = 1'b0;
                    rvld_d   = 1'b1;
                    ridx_d   = idx_q;
                    rdata_d  = rd_lane;
                    if (M_AXI_RRESP_i != 2'b00) err_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        done_d = 1'b1;
                        // A command requested during this very cycle still chains behind the sweep.
                        if (pend_q || rst_cmd_i) begin
                            state_d   = S_AW_W;
                            awaddr_d  = AW'(CMD_BYTE);
                            wdata_d   = cmd_wdata;
                            wstrb_d   = cmd_wstrb;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        araddr_d  = reg_addr(idx_q + IDX_W'(1));
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AW_W: begin
                if (M_AXI_AWREADY_i) awvalid_d = 1'b0;
                if (M_AXI_WREADY_i)  wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY_i) && (!wvalid_q || M_AXI_WREADY_i)) begin
                    state_d  = S_B;
                    bready_d = 1'b1;
                    pend_d   = 1'b0;
                end
            end
            S_B: begin
                if (M_AXI_BVALID_i) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    if (M_AXI_BRESP_i != 2'b00) err_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge M_AXI_ACLK_i or negedge M_AXI_ARESETN_i) begin
        if (!M_AXI_ARESETN_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            rvld_q    <= 1'b0;
            ridx_q    <= '0;
            rdata_q   <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            done_q    <= done_d;
            rvld_q    <= rvld_d;
            ridx_q    <= ridx_d;
            rdata_q   <= rdata_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign reg_valid_o     = rvld_q;
    assign reg_idx_o       = ridx_q;
    assign reg_data_o      = rdata_q;
    assign M_AXI_ARADDR_o  = araddr_q;
    assign M_AXI_ARVALID_o = arvalid_q;
    assign M_AXI_RREADY_o  = rready_q;
    assign M_AXI_AWADDR_o  = awaddr_q;
    assign M_AXI_AWVALID_o = awvalid_q;
    assign M_AXI_WDATA_o   = wdata_q;
    assign M_AXI_WSTRB_o   = wstrb_q;
    assign M_AXI_WVALID_o  = wvalid_q;
    assign M_AXI_BREADY_o  = bready_q;

endmodule

// File: tb/tb_hwinfo_axi_reader.sv
// Randomized scoreboard bench for hwinfo_axi_reader with a behavioural AXI4-Lite slave.
module tb_hwinfo_axi_reader;

    localparam int AW    = 12;
    localparam int DW    = 128;
    localparam int RW    = 64;
    localparam int NREG  = 16;
    localparam int BASE  = 0;
    localparam int CMDA  = 31;
    localparam int RB    = RW / 8;
    localparam int LANES = DW / RW;
    localparam int IW    = $clog2(NREG) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0, rst_cmd_i = 1'b0;
    logic busy_o, done_o, err_o, reg_valid_o;
    logic [IW-1:0] reg_idx_o;
    logic [RW-1:0] reg_data_o;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    hwinfo_axi_reader #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .REG_DATA_WIDTH(RW),
        .REGNUM(NREG), .BASE_ADDR(BASE), .CMD_ADR(CMDA)
    ) dut (
        .M_AXI_ACLK_i(clk), .M_AXI_ARESETN_i(rst_n),
        .start_i(start_i), .rst_cmd_i(rst_cmd_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .reg_valid_o(reg_valid_o), .reg_idx_o(reg_idx_o), .reg_data_o(reg_data_o),
        .M_AXI_AWADDR_o(awaddr), .M_AXI_AWVALID_o(awvalid), .M_AXI_AWREADY_i(awready),
        .M_AXI_WDATA_o(wdata), .M_AXI_WSTRB_o(wstrb), .M_AXI_WVALID_o(wvalid),
        .M_AXI_WREADY_i(wready), .M_AXI_BRESP_i(bresp), .M_AXI_BVALID_i(bvalid),
        .M_AXI_BREADY_o(bready), .M_AXI_ARADDR_o(araddr), .M_AXI_ARVALID_o(arvalid),
        .M_AXI_ARREADY_i(arready), .M_AXI_RDATA_i(rdata), .M_AXI_RRESP_i(rresp),
        .M_AXI_RVALID_i(rvalid), .M_AXI_RREADY_o(rready)
    );

    typedef struct {
        int          idx;
        logic [63:0] data;
        bit          err;
    } exp_reg_t;

    exp_reg_t exp_reg[$];
    int       exp_ar[$];
    bit       exp_done[$];
    int       exp_wr[$];

    int total = 0;
    int bad   = 0;

    logic [63:0] mem [0:31];
    bit  cfg_rand = 1'b0;
    int  cfg_bad  = -1;
    int  cfg_aw_dly = 0, cfg_w_dly = 0;
    logic [1:0] cfg_bresp = 2'b00;

    logic [AW-1:0]   exp_awaddr;
    logic [DW-1:0]   exp_wdata;
    logic [DW/8-1:0] exp_wstrb;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dly(input int maxd);
        return cfg_rand ? int'($urandom_range(maxd, 0)) : 0;
    endfunction

    // Behavioural slave: samples handshakes at negedge, drives its outputs 1 after posedge.
    initial begin : slave
        bit hs_ar, hs_r, hs_aw, hs_w, hs_b, arv_s, awv_s, wv_s;
        bit r_pend, aw_done, w_done, b_pend, done_chk, ar_hold;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ridx, bidx;
        logic [AW-1:0] ar_addr_s, r_addr, aw_addr_s, ar_hold_addr, cap_awaddr;
        logic [DW-1:0] wdata_s, cap_wdata;
        logic [DW/8-1:0] wstrb_s, cap_wstrb;
        {arready, rvalid, awready, wready, bvalid} = '0;
        rdata = '0; rresp = '0; bresp = '0;
        {r_pend, aw_done, w_done, b_pend, done_chk, ar_hold} = '0;
        {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
        r_addr = '0; ar_hold_addr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
        forever begin
            @(negedge clk);
            hs_ar = arvalid && arready; hs_r = rvalid && rready;
            hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
            arv_s = arvalid; awv_s = awvalid; wv_s = wvalid;
            ar_addr_s = araddr; aw_addr_s = awaddr; wdata_s = wdata; wstrb_s = wstrb;
            if (rst_n) begin
                if (ar_hold) begin
                    chk("ar_valid_stable", arvalid, 1'b1);
                    chk("ar_addr_stable", araddr, ar_hold_addr);
                end
                ar_hold = arvalid && !arready;
                ar_hold_addr = araddr;
                if (done_chk) chk("done_after_b", done_o, 1'b1);
                done_chk = 1'b0;
                if (aw_done) chk("awvalid_dropped", awvalid, 1'b0);
                if (w_done)  chk("wvalid_dropped", wvalid, 1'b0);
                if (hs_ar) begin
                    chk("ar_expected", exp_ar.size() > 0, 1'b1);
                    if (exp_ar.size() > 0) chk("araddr", ar_addr_s, exp_ar.pop_front());
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                {arready, rvalid, awready, wready, bvalid} = '0;
                rdata = '0; rresp = '0; bresp = '0;
                {r_pend, aw_done, w_done, b_pend, done_chk, ar_hold} = '0;
            end else begin
                if (hs_ar) begin
                    arready = 1'b0; r_pend = 1'b1; r_addr = ar_addr_s; r_cnt = dly(5);
                end else if (!arv_s) begin
                    ar_cnt = dly(5);
                end else if (!arready) begin
                    if (ar_cnt == 0) arready = 1'b1; else ar_cnt--;
                end
                if (hs_r) begin rvalid = 1'b0; r_pend = 1'b0; end
                if (r_pend && !rvalid) begin
                    if (r_cnt == 0) begin
                        ridx = (int'(r_addr) - BASE) / RB;
                        bidx = ridx - (ridx % LANES);
                        for (int l = 0; l < LANES; l++) rdata[l*RW +: RW] = mem[bidx + l];
                        rresp = (ridx == cfg_bad) ? 2'b10 : 2'b00;
                        rvalid = 1'b1;
                    end else r_cnt--;
                end
                if (hs_b) begin
                    bvalid = 1'b0; b_pend = 1'b0; aw_done = 1'b0; w_done = 1'b0; done_chk = 1'b1;
                end
                if (hs_aw) begin awready = 1'b0; aw_done = 1'b1; cap_awaddr = aw_addr_s; end
                else if (!awv_s && !aw_done) aw_cnt = cfg_aw_dly;
                else if (awv_s && !awready) begin
                    if (aw_cnt == 0) awready = 1'b1; else aw_cnt--;
                end
                if (hs_w) begin wready = 1'b0; w_done = 1'b1; cap_wdata = wdata_s; cap_wstrb = wstrb_s; end
                else if (!wv_s && !w_done) w_cnt = cfg_w_dly;
                else if (wv_s && !wready) begin
                    if (w_cnt == 0) wready = 1'b1; else w_cnt--;
                end
                if (aw_done && w_done && !b_pend) begin
                    chk("write_expected", exp_wr.size() > 0, 1'b1);
                    if (exp_wr.size() > 0) void'(exp_wr.pop_front());
                    chk("awaddr", cap_awaddr, exp_awaddr);
                    chk("wdata", cap_wdata, exp_wdata);
                    chk("wstrb", cap_wstrb, exp_wstrb);
                    b_pend = 1'b1; b_cnt = dly(3);
                end
                if (b_pend && !bvalid) begin
                    if (b_cnt == 0) begin bvalid = 1'b1; bresp = cfg_bresp; end else b_cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: compares every reg_valid_o / done_o pulse against the queues.
    initial begin : monitor
        exp_reg_t e;
        bit de;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_valid_o) begin
                    chk("reg_expected", exp_reg.size() > 0, 1'b1);
                    if (exp_reg.size() > 0) begin
                        e = exp_reg.pop_front();
                        chk("reg_idx", reg_idx_o, e.idx);
                        chk("reg_data", reg_data_o, e.data);
                        chk("reg_err", err_o, e.err);
                    end
                end
                if (done_o) begin
                    chk("done_expected", exp_done.size() > 0, 1'b1);
                    if (exp_done.size() > 0) begin
                        de = exp_done.pop_front();
                        chk("done_err", err_o, de);
                    end
                end
            end
        end
    end

    task automatic flush();
        exp_reg.delete(); exp_ar.delete(); exp_done.delete(); exp_wr.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, err_o, 1'b0);
        chk({tag, "_regvalid"}, reg_valid_o, 1'b0);
        chk({tag, "_regidx"}, reg_idx_o, '0);
        chk({tag, "_regdata"}, reg_data_o, '0);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_araddr"}, araddr, '0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_awvalid"}, awvalid, 1'b0);
        chk({tag, "_awaddr"}, awaddr, '0);
        chk({tag, "_wvalid"}, wvalid, 1'b0);
        chk({tag, "_wdata"}, wdata, '0);
        chk({tag, "_wstrb"}, wstrb, '0);
        chk({tag, "_bready"}, bready, 1'b0);
    endtask

    task automatic start_sweep(input int badreg, input bit with_cmd);
        cfg_bad = badreg;
        for (int k = 0; k < NREG; k++) begin
            exp_reg.push_back('{idx: k, data: mem[k], err: (badreg >= 0 && k >= badreg)});
            exp_ar.push_back(BASE + k * RB);
        end
        exp_done.push_back(badreg >= 0);
        if (with_cmd) begin
            exp_wr.push_back(1);
            exp_done.push_back((badreg >= 0) || (cfg_bresp != 2'b00));
        end
        @(posedge clk); #1;
        start_i = 1'b1; rst_cmd_i = with_cmd;
        @(posedge clk); #1;
        start_i = 1'b0; rst_cmd_i = 1'b0;
        chk("arvalid_after_start", arvalid, 1'b1);
        chk("busy_after_start", busy_o, 1'b1);
        chk("err_cleared_on_start", err_o, 1'b0);
    endtask

    task automatic cmd_only();
        exp_wr.push_back(1);
        exp_done.push_back(cfg_bresp != 2'b00);
        @(posedge clk); #1;
        rst_cmd_i = 1'b1;
        @(posedge clk); #1;
        rst_cmd_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy_o || exp_done.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_completes"}, n < 2000, 1'b1);
        chk({tag, "_regs_consumed"}, exp_reg.size(), 0);
        chk({tag, "_writes_consumed"}, exp_wr.size(), 0);
        if (n >= 2000) flush();
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) mem[k] = {$urandom(), $urandom()};
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        int lane, n;
        exp_awaddr = AW'(BASE + CMDA * RB);
        lane = ((BASE + CMDA * RB) / RB) % LANES;
        exp_wdata = '0;
        exp_wstrb = '0;
        for (int l = 0; l < LANES; l++) begin
            exp_wdata[l*RW +: RW] = 64'hF;
            if (l == lane) exp_wstrb[l*RB +: RB] = '1;
        end

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait sweep with register k = 0x1000+k.
        cfg_rand = 1'b0;
        for (int k = 0; k < 32; k++) mem[k] = 64'h1000 + 64'(k);
        start_sweep(-1, 1'b0);
        wait_idle("sweep_zero_wait");

        // Lane select: register 0 = 0xBBBB (low lane), register 1 = 0xAAAA (high lane).
        cfg_rand = 1'b1;
        fill_random();
        mem[0] = 64'hBBBB;
        mem[1] = 64'hAAAA;
        start_sweep(-1, 1'b0);
        wait_idle("sweep_lanes");

        // Command write alone, AWREADY two cycles ahead of WREADY.
        cfg_rand = 1'b0; cfg_aw_dly = 0; cfg_w_dly = 2; cfg_bresp = 2'b00;
        cmd_only();
        wait_idle("cmd_alone");

        // Start and command together, plus a second command request mid-sweep.
        cfg_rand = 1'b1;
        fill_random();
        start_sweep(-1, 1'b1);
        repeat (20) @(posedge clk);
        #1 rst_cmd_i = 1'b1;
        @(posedge clk); #1 rst_cmd_i = 1'b0;
        wait_idle("sweep_then_cmd");

        // Error response on register 3; sticky through the rest of the sweep.
        fill_random();
        start_sweep(3, 1'b0);
        wait_idle("sweep_rresp_err");
        chk("err_sticky_after_sweep", err_o, 1'b1);
        fill_random();
        start_sweep(-1, 1'b0);
        wait_idle("sweep_after_err");

        // Random stalls with asynchronous reset while a read is outstanding.
        fill_random();
        start_sweep(-1, 1'b0);
        repeat ($urandom_range(40, 10)) @(negedge clk);
        n = 0;
        while (!rready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_r_phase", rready, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        flush();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_random();
        start_sweep(-1, 1'b0);
        wait_idle("sweep_after_reset");

        // Command with error response and skewed write channels.
        cfg_aw_dly = 3; cfg_w_dly = 1; cfg_bresp = 2'b10;
        cmd_only();
        wait_idle("cmd_bresp_err");
        chk("err_after_bresp", err_o, 1'b1);
        cfg_bresp = 2'b00;
        fill_random();
        start_sweep(-1, 1'b0);
        wait_idle("sweep_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
